// File: rtl/ts_pkg.sv
// rtl/ts_pkg.sv - shared constants and FSM encoding for the TS demuxer
package ts_pkg;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PKT_LEN   = 188;
  localparam int         TS_HDR_LEN   = 4;
  localparam int         PID_W        = 13;
  localparam int         CC_W         = 4;

  typedef enum logic [2:0] {
    HUNT,
    HDR,
    DRAIN,
    PAYLOAD,
    DROP
  } ts_state_t;

endpackage

// File: rtl/ts_byte_sync.sv
// rtl/ts_byte_sync.sv - 2-FF capture of the TS input bus and DCLK rising-edge strobe
module ts_byte_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       dclk,
  input  logic [7:0] data,
  input  logic       valid,
  input  logic       psync,
  output logic       strobe,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_psync
);

  // bit 10 = dclk, bit 9 = psync, bit 8 = valid, bits 7:0 = data
  logic [10:0] s1, s2, s3;

  // identical synchroniser chain for all bits; strobe aligns with the stage-3 word that first sees dclk high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      strobe <= 1'b0;
    end else begin
      s1     <= {dclk, psync, valid, data};
      s2     <= s1;
      s3     <= s2;
      strobe <= s2[10] & ~s3[10];
    end
  end

  assign byte_data  = s3[7:0];
  assign byte_valid = s3[8];
  assign byte_psync = s3[9];

endmodule

// File: rtl/ts_demuxer.sv
// rtl/ts_demuxer.sv - TS packet framer, PID router and error flagging for the 4-channel mux
module ts_demuxer
  import ts_pkg::*;
#(
  parameter logic [PID_W-1:0] PID_0 = 13'h1000,
  parameter logic [PID_W-1:0] PID_1 = 13'h1001,
  parameter logic [PID_W-1:0] PID_2 = 13'h1002,
  parameter logic [PID_W-1:0] PID_3 = 13'h1003
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA_IN,
  input  logic       DCLK_IN,
  input  logic       D_VALID_IN,
  input  logic       P_SYNC_IN,
  output logic [7:0] DATA_OUT,
  output logic       VALID_OUT,
  output logic       SOP_OUT,
  output logic       EOP_OUT,
  output logic [1:0] CH_OUT,
  output logic       ABORT_OUT,
  output logic       SYNC_ERR,
  output logic       CC_ERR,
  output logic [1:0] CC_ERR_CH,
  output logic       LEN_ERR
);

  localparam logic [7:0] LAST_IDX = 8'(TS_PKT_LEN - 1);
  localparam logic [7:0] HDR3_IDX = 8'(TS_HDR_LEN - 1);

  logic       strobe, s_valid, s_psync;
  logic [7:0] s_data;

  ts_byte_sync u_sync (
    .clk        (CLK),
    .rst        (RST),
    .dclk       (DCLK_IN),
    .data       (DATA_IN),
    .valid      (D_VALID_IN),
    .psync      (P_SYNC_IN),
    .strobe     (strobe),
    .byte_data  (s_data),
    .byte_valid (s_valid),
    .byte_psync (s_psync)
  );

  ts_state_t       state, state_d;
  logic [7:0]      idx, idx_d;
  logic [1:0]      dcnt, dcnt_d;
  logic [7:0]      hdr [4];
  logic [7:0]      hdr_d [4];
  logic [7:0]      hold, hold_d;
  logic            hold_v, hold_v_d;
  logic [3:0]      cc_seen, cc_seen_d;
  logic [CC_W-1:0] cc_last [4];
  logic [CC_W-1:0] cc_last_d [4];

  logic [7:0] data_d;
  logic       valid_d, sop_d, eop_d, abort_d, sync_err_d, cc_err_d, len_err_d;
  logic [1:0] ch_d, cc_err_ch_d;

  logic             sv, take, hit;
  logic [1:0]       hit_ch;
  logic [PID_W-1:0] pid;
  logic [CC_W-1:0]  exp_cc;

  // PID lookup on the stored header, lowest channel index wins
  always_comb begin
    pid    = {hdr[1][4:0], hdr[2]};
    hit    = 1'b1;
    hit_ch = 2'd0;
    if      (pid == PID_0) hit_ch = 2'd0;
    else if (pid == PID_1) hit_ch = 2'd1;
    else if (pid == PID_2) hit_ch = 2'd2;
    else if (pid == PID_3) hit_ch = 2'd3;
    else                   hit    = 1'b0;
    exp_cc = s_data[4] ? cc_last[hit_ch] + 4'd1 : cc_last[hit_ch];
  end

  // next-state and registered-output logic; a P_SYNC strobe overrides whatever the current state was doing
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    dcnt_d      = dcnt;
    hdr_d       = hdr;
    hold_d      = hold;
    hold_v_d    = hold_v;
    cc_seen_d   = cc_seen;
    cc_last_d   = cc_last;
    data_d      = 8'h00;
    valid_d     = 1'b0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    abort_d     = 1'b0;
    sync_err_d  = 1'b0;
    cc_err_d    = 1'b0;
    len_err_d   = 1'b0;
    ch_d        = CH_OUT;
    cc_err_ch_d = CC_ERR_CH;
    sv          = strobe & s_valid;
    take        = sv & ~s_psync;

    case (state)
      HUNT: ;
      HDR: begin
        if (take) begin
          hdr_d[idx[1:0]] = s_data;
          idx_d           = idx + 8'd1;
          if (idx == HDR3_IDX) begin
            if (hit && !hdr[1][7]) begin
              state_d = DRAIN;
              dcnt_d  = 2'd1;
              ch_d    = hit_ch;
              valid_d = 1'b1;
              data_d  = hdr[0];
              sop_d   = 1'b1;
              if (cc_seen[hit_ch] && s_data[3:0] != exp_cc) begin
                cc_err_d    = 1'b1;
                cc_err_ch_d = hit_ch;
              end
              cc_seen_d[hit_ch] = 1'b1;
              cc_last_d[hit_ch] = s_data[3:0];
            end else begin
              state_d = DROP;
            end
          end
        end
      end
      DRAIN: begin
        valid_d = 1'b1;
        data_d  = hdr[dcnt];
        dcnt_d  = dcnt + 2'd1;
        if (dcnt == 2'd3) state_d = PAYLOAD;
        if (take) begin
          hold_d   = s_data;
          hold_v_d = 1'b1;
          idx_d    = idx + 8'd1;
        end
      end
      PAYLOAD: begin
        if (hold_v) begin
          valid_d  = 1'b1;
          data_d   = hold;
          hold_v_d = 1'b0;
        end else if (take) begin
          valid_d = 1'b1;
          data_d  = s_data;
          idx_d   = idx + 8'd1;
          if (idx == LAST_IDX) begin
            eop_d   = 1'b1;
            state_d = HUNT;
            idx_d   = 8'd0;
          end
        end
      end
      DROP: begin
        if (take) begin
          idx_d = idx + 8'd1;
          if (idx == LAST_IDX) begin
            state_d = HUNT;
            idx_d   = 8'd0;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    if (sv && s_psync) begin
      if (state != HUNT) begin
        len_err_d = 1'b1;
        abort_d   = (state == DRAIN) || (state == PAYLOAD);
      end
      valid_d  = 1'b0;
      data_d   = 8'h00;
      sop_d    = 1'b0;
      eop_d    = 1'b0;
      hold_v_d = 1'b0;
      if (s_data == TS_SYNC_BYTE) begin
        hdr_d[0] = s_data;
        idx_d    = 8'd1;
        state_d  = HDR;
      end else begin
        sync_err_d = 1'b1;
        idx_d      = 8'd0;
        state_d    = HUNT;
      end
    end
  end

  // state, per-channel CC history and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= HUNT;
      idx       <= 8'd0;
      dcnt      <= 2'd0;
      hdr       <= '{default: '0};
      hold      <= 8'h00;
      hold_v    <= 1'b0;
      cc_seen   <= 4'd0;
      cc_last   <= '{default: '0};
      DATA_OUT  <= 8'h00;
      VALID_OUT <= 1'b0;
      SOP_OUT   <= 1'b0;
      EOP_OUT   <= 1'b0;
      CH_OUT    <= 2'd0;
      ABORT_OUT <= 1'b0;
      SYNC_ERR  <= 1'b0;
      CC_ERR    <= 1'b0;
      CC_ERR_CH <= 2'd0;
      LEN_ERR   <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      dcnt      <= dcnt_d;
      hdr       <= hdr_d;
      hold      <= hold_d;
      hold_v    <= hold_v_d;
      cc_seen   <= cc_seen_d;
      cc_last   <= cc_last_d;
      DATA_OUT  <= data_d;
      VALID_OUT <= valid_d;
      SOP_OUT   <= sop_d;
      EOP_OUT   <= eop_d;
      CH_OUT    <= ch_d;
      ABORT_OUT <= abort_d;
      SYNC_ERR  <= sync_err_d;
      CC_ERR    <= cc_err_d;
      CC_ERR_CH <= cc_err_ch_d;
      LEN_ERR   <= len_err_d;
    end
  end

endmodule

// File: tb/tb_ts_demuxer.sv
// tb/tb_ts_demuxer.sv - randomized scoreboard bench for ts_demuxer
module tb_ts_demuxer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] DATA_IN = 8'h00;
  logic       DCLK_IN = 1'b0;
  logic       D_VALID_IN = 1'b0;
  logic       P_SYNC_IN = 1'b0;
  logic [7:0] DATA_OUT;
  logic       VALID_OUT, SOP_OUT, EOP_OUT, ABORT_OUT, SYNC_ERR, CC_ERR, LEN_ERR;
  logic [1:0] CH_OUT, CC_ERR_CH;

  ts_demuxer dut (
    .CLK        (CLK),
    .RST        (RST),
    .DATA_IN    (DATA_IN),
    .DCLK_IN    (DCLK_IN),
    .D_VALID_IN (D_VALID_IN),
    .P_SYNC_IN  (P_SYNC_IN),
    .DATA_OUT   (DATA_OUT),
    .VALID_OUT  (VALID_OUT),
    .SOP_OUT    (SOP_OUT),
    .EOP_OUT    (EOP_OUT),
    .CH_OUT     (CH_OUT),
    .ABORT_OUT  (ABORT_OUT),
    .SYNC_ERR   (SYNC_ERR),
    .CC_ERR     (CC_ERR),
    .CC_ERR_CH  (CC_ERR_CH),
    .LEN_ERR    (LEN_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {logic [7:0] d; logic sop; logic eop; logic [1:0] ch;} out_t;
  typedef struct packed {logic sync; logic cc; logic len; logic abort; logic [1:0] ch;} ev_t;

  out_t       exp_q[$];
  ev_t        ev_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] cur [188];
  bit         cc_seen [4];
  logic [3:0] cc_last [4];
  bit         prev_trunc = 0;
  bit         prev_emit = 0;
  out_t       mon_o;
  ev_t        mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int chan_of(input logic [12:0] pid);
    for (int k = 0; k < 4; k++)
      if (pid == 13'h1000 + 13'(k)) return k;
    return -1;
  endfunction

  // packet-level reference: routing, CC history and length/sync events per segment
  task automatic model_seg(input int len);
    ev_t        e = '0;
    int         ch;
    logic [3:0] cc, expc;
    if (prev_trunc) begin
      e.len   = 1'b1;
      e.abort = prev_emit;
    end
    prev_trunc = 0;
    prev_emit  = 0;
    if (cur[0] != 8'h47) begin
      e.sync = 1'b1;
      ev_q.push_back(e);
      return;
    end
    if (e != '0) ev_q.push_back(e);
    if (len < 4) begin
      prev_trunc = 1;
      return;
    end
    ch = chan_of({cur[1][4:0], cur[2]});
    if (ch >= 0 && !cur[1][7]) begin
      cc   = cur[3][3:0];
      expc = cur[3][4] ? cc_last[ch] + 4'd1 : cc_last[ch];
      if (cc_seen[ch] && cc != expc) ev_q.push_back('{sync: 1'b0, cc: 1'b1, len: 1'b0, abort: 1'b0, ch: 2'(ch)});
      cc_seen[ch] = 1;
      cc_last[ch] = cc;
      for (int i = 0; i < len; i++)
        exp_q.push_back('{d: cur[i], sop: (i == 0), eop: (i == 187), ch: 2'(ch)});
      prev_emit = 1;
    end
    if (len < 188) prev_trunc = 1;
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic ps, input int half);
    DATA_IN    = d;
    D_VALID_IN = v;
    P_SYNC_IN  = ps;
    DCLK_IN    = 1'b0;
    #(half);
    DCLK_IN    = 1'b1;
    #(half);
  endtask

  task automatic pkt(input logic [12:0] pid, input bit tei, input logic [1:0] afc, input logic [3:0] cc,
                     input int len, input int half, input bit gaps, input bit bad_sync);
    cur[0] = bad_sync ? 8'h48 : 8'h47;
    cur[1] = {tei, 1'b1, 1'b0, pid[12:8]};
    cur[2] = pid[7:0];
    cur[3] = {2'b00, afc, cc};
    for (int i = 4; i < 188; i++) cur[i] = 8'($urandom);
    model_seg(len);
    for (int i = 0; i < len; i++) begin
      if (gaps) drive(8'($urandom), 1'b0, 1'($urandom), half);
      drive(cur[i], 1'b1, (i == 0), half);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a byte or an error pulse
  always @(negedge CLK) begin
    if (!RST) begin
      if (VALID_OUT) begin
        if (exp_q.size() == 0) chk("unexpected_byte_queue", 32'(exp_q.size()), 32'd1);
        else begin
          mon_o = exp_q.pop_front();
          chk("out_byte", 32'({DATA_OUT, SOP_OUT, EOP_OUT, CH_OUT}), 32'(mon_o));
        end
      end
      if (SYNC_ERR || CC_ERR || LEN_ERR || ABORT_OUT) begin
        if (ev_q.size() == 0) chk("unexpected_event_queue", 32'(ev_q.size()), 32'd1);
        else begin
          mon_e = ev_q.pop_front();
          chk("event", 32'({SYNC_ERR, CC_ERR, LEN_ERR, ABORT_OUT, (CC_ERR ? CC_ERR_CH : 2'b00)}), 32'(mon_e));
        end
      end
    end
  end

  initial begin
    logic [12:0] rpid;
    int          ridx;
    #12;
    chk("reset_outputs", 32'({DATA_OUT, VALID_OUT, SOP_OUT, EOP_OUT, CH_OUT, ABORT_OUT, SYNC_ERR, CC_ERR, CC_ERR_CH, LEN_ERR}), 32'd0);
    #20;
    RST = 1'b0;

    for (int c = 0; c < 3; c++) pkt(13'h1001, 0, 2'b01, 4'(c), 188, 40, 0, 0);

    pkt(13'h0100, 0, 2'b01, 4'd0, 188, 40, 0, 0);
    pkt(13'h1000, 1, 2'b01, 4'd0, 188, 40, 0, 0);
    pkt(13'h1000, 0, 2'b01, 4'd0, 188, 40, 0, 0);

    pkt(13'h1000, 0, 2'b01, 4'd1, 188, 40, 0, 1);
    pkt(13'h1000, 0, 2'b01, 4'd1, 188, 40, 0, 0);

    pkt(13'h1002, 0, 2'b01, 4'd3, 188, 40, 0, 0);
    pkt(13'h1002, 0, 2'b01, 4'd4, 188, 40, 0, 0);
    pkt(13'h1002, 0, 2'b01, 4'd6, 188, 40, 0, 0);
    pkt(13'h1002, 0, 2'b10, 4'd6, 188, 40, 0, 0);

    pkt(13'h1003, 0, 2'b01, 4'd5, 100, 40, 0, 0);
    pkt(13'h1003, 0, 2'b01, 4'd6, 188, 40, 0, 0);

    pkt(13'h1001, 0, 2'b01, 4'd3, 188, 40, 1, 0);
    pkt(13'h1001, 0, 2'b01, 4'd4, 188, 40, 1, 0);

    pkt(13'h1000, 0, 2'b01, 4'd2, 188, 15, 0, 0);

    pkt(13'h1003, 0, 2'b01, 4'd7, 100, 40, 0, 0);
    DCLK_IN    = 1'b0;
    D_VALID_IN = 1'b0;
    P_SYNC_IN  = 1'b0;
    #100;
    RST = 1'b1;
    #1;
    chk("reset_mid_packet", 32'({DATA_OUT, VALID_OUT, SOP_OUT, EOP_OUT, CH_OUT, ABORT_OUT, SYNC_ERR, CC_ERR, CC_ERR_CH, LEN_ERR}), 32'd0);
    for (int k = 0; k < 4; k++) cc_seen[k] = 0;
    prev_trunc = 0;
    prev_emit  = 0;
    #19;
    RST = 1'b0;
    pkt(13'h1001, 0, 2'b01, 4'd9, 188, 40, 0, 0);
    pkt(13'h1003, 0, 2'b01, 4'd0, 188, 40, 0, 0);
    pkt(13'h1002, 0, 2'b01, 4'd15, 188, 40, 0, 0);

    for (int r = 0; r < 6; r++) begin
      ridx = $urandom_range(0, 4);
      rpid = (ridx < 4) ? 13'h1000 + 13'(ridx) : 13'h0200 + 13'($urandom_range(0, 255));
      pkt(rpid, ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), 4'($urandom),
          ($urandom_range(0, 3) == 0) ? $urandom_range(2, 187) : 188, 40, 0, 0);
    end
    pkt(13'h1000, 0, 2'b01, 4'($urandom), 188, 40, 0, 0);

    DCLK_IN    = 1'b0;
    D_VALID_IN = 1'b0;
    #400;
    chk("bytes_outstanding", 32'(exp_q.size()), 32'd0);
    chk("events_outstanding", 32'(ev_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
